// File: rtl/aes_key_sched_ctrl_if.sv
// Request/response bundle between the cipher round controller and the
// AES-128 round-key scheduler: key load, expansion status, and the
// indexed round-key read port.
interface aes_key_sched_ctrl_if;
  logic         key_load;
  logic [127:0] key_in;
  logic         busy;
  logic         key_ready;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic [127:0] rk_out;
  logic         rk_err;

  // Cipher side: loads keys and issues round-key reads.
  modport master (
    output key_load, key_in, rk_req, rk_idx,
    input  busy, key_ready, rk_valid, rk_out, rk_err
  );

  // Scheduler side.
  modport slave (
    input  key_load, key_in, rk_req, rk_idx,
    output busy, key_ready, rk_valid, rk_out, rk_err
  );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key scheduler. One round key is derived per cycle
// using a single 4-byte S-box (shared g-function) and written to an
// 11-entry store. Round keys are served by index. A read stalls until the
// requested entry has been written, so the cipher may start reading
// before expansion finishes.
module aes_key_sched_ctrl #(
  parameter int NUM_ROUNDS = 10,  // only 10 (AES-128) is meaningful
  parameter int KEY_W      = 128
) (
  input logic           clk,
  input logic           rst_n,
  aes_key_sched_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       rnd_q, rnd_d;
  logic [3:0]       valid_cnt_q, valid_cnt_d;
  // Copy of the most recently written round key; it feeds the next step
  // so the store needs only one read port (the cipher's).
  logic [KEY_W-1:0] cur_key_q, cur_key_d;

  logic [KEY_W-1:0] store_q [0:NUM_ROUNDS];

  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [KEY_W-1:0] wr_data;

  logic             rk_valid_q, rk_err_q;
  logic [KEY_W-1:0] rk_out_q;

  logic             idx_oob;
  logic             rd_accept;

  // GF(2^8) multiply by x modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as multiplicative inverse (x^254, with 0 -> 0)
  // followed by the AES affine transform, instead of a 256-entry table.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s;
    logic [7:0] r;
    s = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Shared g-function: RotWord, one 4-byte SubWord, rcon on the top byte.
  logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
  logic [31:0] rot_w, sub_w, g_w;
  logic [KEY_W-1:0] next_key;

  assign w0    = cur_key_q[127:96];
  assign w1    = cur_key_q[95:64];
  assign w2    = cur_key_q[63:32];
  assign w3    = cur_key_q[31:0];
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sub
    assign sub_w[gi*8 +: 8] = sbox(rot_w[gi*8 +: 8]);
  end

  assign g_w      = sub_w ^ {rcon(rnd_q), 24'h000000};
  assign w4       = w0 ^ g_w;
  assign w5       = w1 ^ w4;
  assign w6       = w2 ^ w5;
  assign w7       = w3 ^ w6;
  assign next_key = {w4, w5, w6, w7};

  // A read is served once its entry exists; out-of-range indices answer
  // immediately with an error. A key load in the same cycle always wins.
  assign idx_oob   = bus.rk_idx > 4'(NUM_ROUNDS);
  assign rd_accept = bus.rk_req && !bus.key_load &&
                     ((bus.rk_idx < valid_cnt_q) || idx_oob);

  // Next-state logic: load restarts from any state, EXPAND writes one key per cycle.
  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    valid_cnt_d = valid_cnt_q;
    cur_key_d   = cur_key_q;
    wr_en       = 1'b0;
    wr_addr     = 4'd0;
    wr_data     = '0;
    if (bus.key_load) begin
      state_d     = EXPAND;
      rnd_d       = 4'd1;
      valid_cnt_d = 4'd1;
      cur_key_d   = bus.key_in;
      wr_en       = 1'b1;
      wr_addr     = 4'd0;
      wr_data     = bus.key_in;
    end else begin
      case (state_q)
        EXPAND: begin
          wr_en       = 1'b1;
          wr_addr     = rnd_q;
          wr_data     = next_key;
          cur_key_d   = next_key;
          valid_cnt_d = rnd_q + 4'd1;
          rnd_d       = rnd_q + 4'd1;
          if (rnd_q == 4'(NUM_ROUNDS)) state_d = DONE;
        end
        default: ;
      endcase
    end
  end

  // Control/state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rnd_q       <= 4'd0;
      valid_cnt_q <= 4'd0;
      cur_key_q   <= '0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      valid_cnt_q <= valid_cnt_d;
      cur_key_q   <= cur_key_d;
    end
  end

  // Round-key store: single write port, contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) store_q[wr_addr] <= wr_data;
  end

  // Registered read port; rk_out holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_valid_q <= 1'b0;
      rk_err_q   <= 1'b0;
      rk_out_q   <= '0;
    end else if (rd_accept) begin
      rk_valid_q <= 1'b1;
      rk_err_q   <= idx_oob;
      rk_out_q   <= idx_oob ? '0 : store_q[bus.rk_idx];
    end else begin
      rk_valid_q <= 1'b0;
      rk_err_q   <= 1'b0;
    end
  end

  assign bus.busy      = (state_q == EXPAND);
  assign bus.key_ready = (state_q == DONE);
  assign bus.rk_valid  = rk_valid_q;
  assign bus.rk_err    = rk_err_q;
  assign bus.rk_out    = rk_out_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: directed FIPS-197 vectors, scoreboard of
// expected reads popped by an independent monitor on every rk_valid.
module tb_aes_key_sched_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_key_sched_ctrl_if bus();

  aes_key_sched_ctrl #(.NUM_ROUNDS(10), .KEY_W(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [127:0] d;
    logic         e;
  } exp_t;

  exp_t         sb_q[$];
  int           n_checks = 0;
  int           n_err    = 0;
  logic [127:0] fips [0:10];
  logic [127:0] key2;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every rk_valid pulse must match the oldest expected read.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.rk_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_rk_valid: got data=%h err=%b expected no pulse",
                 bus.rk_out, bus.rk_err);
      end else begin
        e = sb_q.pop_front();
        chk("rk_out", bus.rk_out, e.d);
        chk("rk_err", 128'(bus.rk_err), 128'(e.e));
        $display("read  data=%h err=%b", bus.rk_out, bus.rk_err);
      end
    end
  end

  // Called at a negedge; returns at the negedge where rk_valid is seen.
  task automatic do_req(input logic [3:0] idx, input logic [127:0] exp_d,
                        input logic exp_e, output int waits);
    sb_q.push_back(exp_t'{d: exp_d, e: exp_e});
    bus.rk_req = 1'b1;
    bus.rk_idx = idx;
    waits = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      waits++;
    end while (bus.rk_valid !== 1'b1 && waits < 40);
    if (bus.rk_valid !== 1'b1) begin
      n_checks++;
      n_err++;
      $display("FAIL req_timeout: idx %0d got no rk_valid expected one", idx);
      void'(sb_q.pop_back());
    end
    bus.rk_req = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic do_load(input logic [127:0] k);
    bus.key_load = 1'b1;
    bus.key_in   = k;
    @(posedge clk);
    @(negedge clk);
    bus.key_load = 1'b0;
    bus.key_in   = ~k;
    $display("load  key=%h", k);
  endtask

  // n = edges counted from the load edge until key_ready is seen.
  task automatic wait_ready(output int n, output logic busy_ok);
    n = 1;
    busy_ok = 1'b1;
    while (bus.key_ready !== 1'b1 && n < 30) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int   w;
    int   n;
    logic ok;

    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    key2     = 128'h000102030405060708090a0b0c0d0e0f;

    bus.key_load = 1'b0;
    bus.key_in   = '0;
    bus.rk_req   = 1'b0;
    bus.rk_idx   = 4'd0;

    repeat (3) @(negedge clk);
    chk("reset_busy",      128'(bus.busy),      128'(0));
    chk("reset_key_ready", 128'(bus.key_ready), 128'(0));
    chk("reset_rk_valid",  128'(bus.rk_valid),  128'(0));
    chk("reset_rk_err",    128'(bus.rk_err),    128'(0));
    chk("reset_rk_out",    bus.rk_out,          128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Out-of-range reads in IDLE still answer with an error.
    do_req(4'd12, 128'(0), 1'b1, w);
    chk("idle_oob_latency", 128'(w), 128'(1));
    do_req(4'd15, 128'(0), 1'b1, w);

    // FIPS-197 expansion and ready timing.
    do_load(fips[0]);
    wait_ready(n, ok);
    chk("ready_latency", 128'(n), 128'(11));
    chk("busy_during_expand", 128'(ok), 128'(1));
    chk("busy_after_expand", 128'(bus.busy), 128'(0));
    do_req(4'd1,  fips[1],  1'b0, w);
    do_req(4'd10, fips[10], 1'b0, w);
    do_req(4'd0,  fips[0],  1'b0, w);

    // Early read of idx 5 one cycle after load.
    do_load(fips[0]);
    do_req(4'd5, fips[5], 1'b0, w);
    chk("early_read_latency", 128'(w), 128'(6));
    wait_ready(n, ok);

    // Streaming 0..10 back to back.
    for (int i = 0; i <= 10; i++) begin
      do_req(4'(i), fips[i], 1'b0, w);
      chk("stream_latency", 128'(w), 128'(1));
    end

    // Error response after ready.
    do_req(4'd12, 128'(0), 1'b1, w);

    // Request colliding with a load: load wins, request served next edge.
    sb_q.push_back(exp_t'{d: 128'(0), e: 1'b0});
    bus.key_load = 1'b1;
    bus.key_in   = 128'(0);
    bus.rk_req   = 1'b1;
    bus.rk_idx   = 4'd0;
    @(posedge clk);
    @(negedge clk);
    bus.key_load = 1'b0;
    chk("collision_not_accepted", 128'(bus.rk_valid), 128'(0));
    @(posedge clk);
    @(negedge clk);
    bus.rk_req = 1'b0;
    chk("collision_then_accepted", 128'(bus.rk_valid), 128'(1));
    wait_ready(n, ok);

    // Restart: zero key aborted at expansion cycle 4, then FIPS key.
    do_load(128'(0));
    ok = 1'b1;
    repeat (3) begin
      if (bus.busy !== 1'b1) ok = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    if (bus.busy !== 1'b1) ok = 1'b0;
    do_load(fips[0]);
    chk("restart_busy_held", 128'(ok), 128'(1));
    wait_ready(n, ok);
    chk("restart_ready_latency", 128'(n), 128'(11));
    chk("restart_busy", 128'(ok), 128'(1));
    do_req(4'd10, fips[10], 1'b0, w);
    do_req(4'd4,  fips[4],  1'b0, w);

    // Asynchronous reset at expansion cycle 6.
    do_load(fips[0]);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",      128'(bus.busy),      128'(0));
    chk("arst_key_ready", 128'(bus.key_ready), 128'(0));
    chk("arst_rk_valid",  128'(bus.rk_valid),  128'(0));
    chk("arst_rk_out",    bus.rk_out,          128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // idx 0 stalls until a new key is loaded.
    sb_q.push_back(exp_t'{d: key2, e: 1'b0});
    bus.rk_req = 1'b1;
    bus.rk_idx = 4'd0;
    ok = 1'b1;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.rk_valid !== 1'b0) ok = 1'b0;
    end
    chk("post_reset_stall", 128'(ok), 128'(1));
    bus.key_load = 1'b1;
    bus.key_in   = key2;
    w = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      bus.key_load = 1'b0;
      w++;
    end while (bus.rk_valid !== 1'b1 && w < 40);
    bus.rk_req = 1'b0;
    chk("post_reset_read_latency", 128'(w), 128'(2));

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 128'(sb_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
